// File: rtl/alu_issue_ctrl.sv
// Operand-issue and write-back controller feeding a DW-bit ALU from a
// 4-entry register file, with immediate loads bypassing the ALU.
module alu_issue_ctrl #(
  parameter int unsigned DW      = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [11:0]   in_instr,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in0,
  output logic          alu_cin,
  output logic [2:0]    alu_instr,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_cout,
  output logic          c_flag,
  output logic          done,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [DW-1:0] rf [4];
  logic [1:0]    rd_q;
  logic          wb_en_q;

  // Instruction field decode
  logic [2:0] f_op;
  logic [1:0] f_rd;
  logic [1:0] f_rs1;
  logic [1:0] f_rs0;
  logic       f_use_carry;
  logic       f_wb_en;
  logic       f_imm;
  logic       accept;

  assign f_op        = in_instr[11:9];
  assign f_rd        = in_instr[8:7];
  assign f_rs1       = in_instr[6:5];
  assign f_rs0       = in_instr[4:3];
  assign f_use_carry = in_instr[2];
  assign f_wb_en     = in_instr[1];
  assign f_imm       = in_instr[0];

  // Ready is a pure decode of state and reset, independent of in_valid
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign dbg_data = rf[dbg_addr];

  // State and latency-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: immediates stay in IDLE, ALU ops walk EXEC -> WB -> IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && !f_imm) begin
          state_nxt = EXEC;
          cnt_nxt   = CW'(ALU_LAT - 1);
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nxt = WB;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand issue at accept, rf/flag update at immediate or WB exit
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      c_flag    <= 1'b0;
      alu_in1   <= '0;
      alu_in0   <= '0;
      alu_cin   <= 1'b0;
      alu_instr <= 3'b000;
      done      <= 1'b0;
      rd_q      <= 2'd0;
      wb_en_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (f_imm) begin
          rf[f_rd] <= DW'(in_instr[6:3]);
          done     <= 1'b1;
        end else begin
          alu_in1   <= rf[f_rs1];
          alu_in0   <= rf[f_rs0];
          alu_instr <= f_op;
          alu_cin   <= f_use_carry ? c_flag : 1'b0;
          rd_q      <= f_rd;
          wb_en_q   <= f_wb_en;
        end
      end
      if (state == WB) begin
        c_flag <= alu_cout;
        if (wb_en_q) rf[rd_q] <= alu_out;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered adder standing in for the ALU.
module tb_alu_issue_ctrl;

  localparam int unsigned DW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [11:0]   in_instr;
  logic [DW-1:0] alu_in1;
  logic [DW-1:0] alu_in0;
  logic          alu_cin;
  logic [2:0]    alu_instr;
  logic [DW-1:0] alu_out;
  logic          alu_cout;
  logic          c_flag;
  logic          done;
  logic [1:0]    dbg_addr;
  logic [DW-1:0] dbg_data;

  int passed;
  int total;

  alu_issue_ctrl #(.DW(DW), .ALU_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_in1   (alu_in1),
    .alu_in0   (alu_in0),
    .alu_cin   (alu_cin),
    .alu_instr (alu_instr),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .c_flag    (c_flag),
    .done      (done),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: registered add, opcode ignored
  always_ff @(posedge clk) begin
    {alu_cout, alu_out} <= 5'(alu_in1) + 5'(alu_in0) + 5'(alu_cin);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_rf(input string tag, input logic [1:0] idx, input logic [3:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, 8'(dbg_data), 8'(exp));
  endtask

  function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] val);
    return {3'b000, rd, val, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic logic [11:0] aop(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs0,
                                      input logic uc, input logic wb);
    return {op, rd, rs1, rs0, uc, wb, 1'b0};
  endfunction

  initial begin
    passed   = 0;
    total    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    dbg_addr = 2'd0;
    tick();
    tick();
    rst = 1'b0;

    // Some traffic, then a reset landing while an ALU op is in EXEC
    in_valid = 1'b1;
    in_instr = ldi(2'd0, 4'd7);
    tick();
    in_instr = aop(3'b001, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_ready_lo0", 8'(in_ready), 8'd0);
    tick();
    chk("rst_ready_lo1", 8'(in_ready), 8'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready_hi", 8'(in_ready), 8'd1);
    chk("rst_cflag", 8'(c_flag), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_in1", 8'(alu_in1), 8'd0);
    chk_rf("rst_r0", 2'd0, 4'd0);
    chk_rf("rst_r1", 2'd1, 4'd0);
    chk_rf("rst_r2", 2'd2, 4'd0);
    chk_rf("rst_r3", 2'd3, 4'd0);

    // Back-to-back immediates
    in_valid = 1'b1;
    in_instr = ldi(2'd1, 4'd1);
    tick();
    chk("ldi1_done", 8'(done), 8'd1);
    chk("ldi1_ready", 8'(in_ready), 8'd1);
    in_instr = ldi(2'd2, 4'd2);
    tick();
    chk("ldi2_done", 8'(done), 8'd1);
    in_valid = 1'b0;
    tick();
    chk("ldi_done_lo", 8'(done), 8'd0);
    chk_rf("ldi_r1", 2'd1, 4'd1);
    chk_rf("ldi_r2", 2'd2, 4'd2);

    // ALU op r3 = r1 + r2
    in_valid = 1'b1;
    in_instr = aop(3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("op_in1", 8'(alu_in1), 8'd1);
    chk("op_in0", 8'(alu_in0), 8'd2);
    chk("op_cin", 8'(alu_cin), 8'd0);
    chk("op_instr", 8'(alu_instr), 8'd1);
    chk("op_ready_e0", 8'(in_ready), 8'd0);
    chk("op_done_e0", 8'(done), 8'd0);
    tick();
    chk("op_ready_e1", 8'(in_ready), 8'd0);
    chk("op_done_e1", 8'(done), 8'd0);
    tick();
    chk("op_ready_e2", 8'(in_ready), 8'd1);
    chk("op_done_e2", 8'(done), 8'd1);
    chk("op_cflag", 8'(c_flag), 8'd0);
    chk_rf("op_r3", 2'd3, 4'd3);
    tick();
    chk("op_done_e3", 8'(done), 8'd0);
    chk("op_hold_in1", 8'(alu_in1), 8'd1);

    // Carry chain: 10 + 11 -> r0 = 5, carry; then 5 + 5 + 1 = 11, no carry
    in_valid = 1'b1;
    in_instr = ldi(2'd1, 4'd10);
    tick();
    in_instr = ldi(2'd2, 4'd11);
    tick();
    in_instr = aop(3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk_rf("cc1_r0", 2'd0, 4'd5);
    chk("cc1_cflag", 8'(c_flag), 8'd1);
    in_valid = 1'b1;
    in_instr = aop(3'b010, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("cc2_cin", 8'(alu_cin), 8'd1);
    chk("cc2_in1", 8'(alu_in1), 8'd5);
    chk("cc2_instr", 8'(alu_instr), 8'd2);
    tick();
    tick();
    chk("cc2_done", 8'(done), 8'd1);
    chk("cc2_cflag", 8'(c_flag), 8'd0);
    chk_rf("cc2_r0", 2'd0, 4'd11);

    // No write-back, with in_valid held through EXEC and WB
    in_valid = 1'b1;
    in_instr = ldi(2'd1, 4'd15);
    tick();
    in_instr = ldi(2'd2, 4'd1);
    tick();
    in_instr = aop(3'b011, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0);
    tick();
    chk("nwb_ready_e0", 8'(in_ready), 8'd0);
    tick();
    chk("nwb_ready_e1", 8'(in_ready), 8'd0);
    chk("nwb_done_e1", 8'(done), 8'd0);
    tick();
    in_valid = 1'b0;
    chk("nwb_done", 8'(done), 8'd1);
    chk("nwb_ready_e2", 8'(in_ready), 8'd1);
    chk("nwb_cflag", 8'(c_flag), 8'd1);
    chk_rf("nwb_r3", 2'd3, 4'd3);
    tick();
    chk("nwb_done_lo", 8'(done), 8'd0);
    chk("nwb_ready_idle", 8'(in_ready), 8'd1);

    // Reset during WB aborts the op
    in_valid = 1'b1;
    in_instr = ldi(2'd1, 4'd2);
    tick();
    in_instr = ldi(2'd2, 4'd3);
    tick();
    in_instr = aop(3'b001, 2'd3, 2'd1, 2'd2, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_done", 8'(done), 8'd0);
    chk("mid_cflag", 8'(c_flag), 8'd0);
    chk("mid_ready", 8'(in_ready), 8'd1);
    chk_rf("mid_r1", 2'd1, 4'd0);
    chk_rf("mid_r2", 2'd2, 4'd0);
    chk_rf("mid_r3", 2'd3, 4'd0);
    in_valid = 1'b1;
    in_instr = ldi(2'd2, 4'd6);
    tick();
    in_valid = 1'b0;
    chk("post_done", 8'(done), 8'd1);
    chk_rf("post_r2", 2'd2, 4'd6);
    tick();
    chk("post_done_lo", 8'(done), 8'd0);
    chk_rf("post_r3", 2'd3, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Operand-issue and write-back controller that sits directly upstream of the 4-bit `alu` in the simple microprocessor. It accepts encoded instruction words over a valid/ready handshake and reads operands from a 4-entry register file. It drives the ALU's `in1`/`in0`/`cin`/`instr` inputs, then captures `out`/`cout` back into the register file and a carry flag. Immediate loads bypass the ALU.

## Interface
- `DW`, 4, data width (matches ALU operand width)
- `ALU_LAT`, 1, clock edges from operand presentation to ALU result valid (≥1)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- `in_valid`  in  1  instruction word valid
- `in_ready`  out  1  controller can accept; high only in IDLE and not in reset
- `in_instr`  in  12  [11:9] op, [8:7] rd, [6:5] rs1, [4:3] rs0, [2] use_carry, [1] wb_en, [0] imm
- `alu_in1`  out  DW  operand to ALU `in1` (registered)
- `alu_in0`  out  DW  operand to ALU `in0` (registered)
- `alu_cin`  out  1  carry-in to ALU (registered)
- `alu_instr`  out  3  opcode to ALU (registered)
- `alu_out`  in  DW  ALU result
- `alu_cout`  in  1  ALU carry-out
- `c_flag`  out  1  stored carry flag
- `done`  out  1  one-cycle pulse, instruction retired
- `dbg_addr`  in  2  debug read address
- `dbg_data`  out  DW  combinational rf[dbg_addr]

## Operation
- Handshake: transfer on the rising edge where `in_valid && in_ready`. `in_instr` is ignored otherwise. `in_valid` may stay high while `in_ready` is low; no transfer occurs.
- Immediate (imm=1): at the accept edge, rf[rd] ← in_instr[6:3]. Other fields, `wb_en`, and `c_flag` are ignored and the ALU outputs are unchanged. State stays IDLE, so back-to-back accepts are allowed.
- ALU op (imm=0) uses FSM states IDLE → EXEC → WB → IDLE:
  - At the accept edge: alu_in1 ← rf[rs1], alu_in0 ← rf[rs0], alu_instr ← op, alu_cin ← use_carry ? c_flag : 0. Go to EXEC and load the wait counter with ALU_LAT-1.
  - EXEC: hold the ALU outputs. Decrement the counter; at the edge where it is 0, go to WB.
  - WB: at the exiting edge, c_flag ← alu_cout (always). If wb_en, rf[rd] ← alu_out. Go to IDLE.
- ALU outputs hold their last value in IDLE.
- rd may equal rs1/rs0. Operands are sampled at accept, so the write-back never affects the current operands.
- Arithmetic is performed by the ALU only. The controller never modifies the result; width is exactly DW and there is no sign handling.
- Debug port reads the rf combinationally. A same-edge write shows on `dbg_data` in the following cycle.
- Reset (`rst` high at an edge) sets:
  - FSM to IDLE, all rf entries to 0, c_flag to 0
  - alu_in1/alu_in0 to 0, alu_cin to 0, alu_instr to 3'b000
  - done to 0, and `in_ready` to 0 while `rst` is high
- Reset mid-operation (EXEC or WB) aborts: no write-back, no done pulse, in-flight instruction discarded.

## Timing
- `done` is registered: high for exactly the one cycle after the rf/flag write edge (accept edge for imm, WB-exit edge for ALU ops).
- For ALU_LAT=1, with accept at edge E0:
  - Operands are stable from E0 until the next accept.
  - EXEC spans E0–E1 and WB spans E1–E2; the write happens at E2.
  - `done` is high in the E2–E3 cycle.
  - `in_ready` is low for 2 cycles; the earliest next accept is at E2's following edge, E3.
- General ALU-op occupancy: ALU_LAT+1 cycles with `in_ready` low. Throughput is one ALU op per ALU_LAT+2 cycles.
- Immediate ops: one per cycle.
- `in_ready` is a combinational decode of state and `rst`. It never depends on `in_valid`.

## Test plan
Bench uses a stub ALU: {cout,out} ← in1+in0+cin, registered at every edge (ALU_LAT=1). The stub ignores `instr`; the bench checks `alu_instr` pass-through.

- Reset: `rst` high 2 cycles after random traffic → `in_ready`=0 during reset and 1 in the first cycle after; dbg reads 0 for r0–r3; c_flag=0; done=0.
- Immediates: LDI r1=1 and LDI r2=2 on consecutive cycles → both accepted; dbg r1=1, r2=2; done high in two consecutive cycles.
- ALU op: op=001, rd=r3, rs1=r1, rs0=r2, use_carry=0, wb_en=1 → cycle after accept shows alu_in1=1, alu_in0=2, alu_cin=0, alu_instr=001. Then r3=3, c_flag=0, done one cycle after E2, and `in_ready` low exactly 2 cycles.
- Carry chain: LDI r1=10, LDI r2=11, then add into r0 → r0=5, c_flag=1. Next op r0+r0 with use_carry=1 → alu_cin=1, r0=11, c_flag=0.
- No write-back: wb_en=0 with operands 15+1 → rd unchanged, c_flag=1, done still pulses. Holding `in_valid` during EXEC/WB causes no extra accept.
- Reset mid-op: assert `rst` in the WB cycle of r3=r1+r2 → no done pulse, all rf entries 0, c_flag 0. The controller accepts a new LDI in the first cycle after reset release.
